// File: rtl/serial_paralelo_sync.sv
// rtl/serial_paralelo_sync.sv - serial-to-parallel lane receiver with COM alignment and lock tracking
module serial_paralelo_sync #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] COM      = 8'hBC,
  parameter int unsigned      COM_LOCK = 4,
  parameter int unsigned      GAP_MAX  = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             word_strobe,
  output logic             active,
  output logic             lock_lost
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(COM_LOCK + 1);
  localparam int unsigned GW = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] COM_LAST  = CW'(COM_LOCK - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_MAX - 1);
  localparam logic [GW-1:0] GAP_SAT   = {GW{1'b1}};

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  state_t           state_q, state_d;
  // Only WIDTH-1 history bits are kept; the incoming bit completes the word.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    com_cnt_q, com_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic             lost_q, lost_d;

  logic [WIDTH-1:0] nxt;
  logic             boundary;
  logic             is_com;

  assign nxt      = {sr_q, data_in};
  assign boundary = (bit_cnt_q == BIT_LAST);
  assign is_com   = (nxt == COM);

  always_comb begin
    state_d   = state_q;
    sr_d      = nxt[WIDTH-2:0];
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    lost_d    = 1'b0;

    case (state_q)
      SEARCH: begin
        bit_cnt_d = '0;
        if (is_com) begin
          com_cnt_d = CW'(1);
          if (COM_LOCK == 1) begin
            state_d   = ACTIVE;
            gap_cnt_d = '0;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + 1'b1;
            if (com_cnt_q == COM_LAST) begin
              state_d   = ACTIVE;
              gap_cnt_d = '0;
            end
          end else begin
            state_d   = SEARCH;
            com_cnt_d = '0;
            bit_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        if (boundary) begin
          // The word that trips the gap timeout is swallowed, not delivered.
          if (GAP_MAX != 0 && !is_com && gap_cnt_q == GAP_LAST) begin
            state_d   = SEARCH;
            valid_d   = 1'b0;
            lost_d    = 1'b1;
            gap_cnt_d = '0;
            com_cnt_d = '0;
            bit_cnt_d = '0;
          end else begin
            data_d   = nxt;
            strobe_d = 1'b1;
            valid_d  = !is_com;
            if (is_com) begin
              gap_cnt_d = '0;
            end else if (gap_cnt_q != GAP_SAT) begin
              gap_cnt_d = gap_cnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      lost_q    <= lost_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign word_strobe = strobe_q;
  assign lock_lost   = lost_q;
  assign active      = (state_q == ACTIVE);

endmodule
